// File: rtl/ets_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ets_pkg
// Description : Shared definitions for the equivalent-time-sampling blocks:
//               sweep sequencer state encoding, DRAIN length and the
//               accumulator data width.
// Revision    : 1.0 - initial release
// ============================================================================
package ets_pkg;

    // Accumulator count width, shared with the accumulator itself.
    localparam int ETS_DATA_W    = 32;

    // Cycles the sequencer holds ets_start low after each accumulate so the
    // accumulator can walk DONE -> CLR -> IDLE before the next start.
    localparam int ETS_DRAIN_CYC = 2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETTLE = 3'd1,
        ST_RUN    = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_OUT    = 3'd4
    } ets_sweep_state_t;

endpackage
`default_nettype wire

// File: rtl/ets_step_timer.sv
`default_nettype none
// ============================================================================
// Module      : ets_step_timer
// Description : Loadable down-counter with a zero flag. Load has priority over
//               decrement; the count holds at zero.
// Ports       : clk, rst_n (sync, active-low), load/load_val, dec, zero
// Revision    : 1.0 - initial release
// ============================================================================
module ets_step_timer #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= load_val;
        end else if (dec && (r_count != '0)) begin
            r_count <= r_count - CNT_W'(1);
        end
    end

    assign zero = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/ets_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : ets_sweep_ctrl
// Description : ETS sweep sequencer. Steps phase_sel through cfg_num_steps
//               phases; per phase: settle, run one accumulate (start/done),
//               drain, then emit (phase, count) on a valid/ready stream.
// Ports       : clk, rst_n (sync, active-low)
//               sweep_start/sweep_abort, cfg_num_steps/cfg_settle/cfg_timeout
//               phase_sel, ets_start, ets_done, ets_data   (accumulator side)
//               res_valid/res_ready/res_phase/res_data     (result stream)
//               busy, sweep_done, err_timeout, err_abort   (status)
// Revision    : 1.0 - initial release
// ============================================================================
module ets_sweep_ctrl
    import ets_pkg::*;
#(
    parameter int PHASE_W  = 8,
    parameter int SETTLE_W = 16,
    parameter int TMO_W    = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  sweep_start,
    input  logic                  sweep_abort,
    input  logic [PHASE_W-1:0]    cfg_num_steps,
    input  logic [SETTLE_W-1:0]   cfg_settle,
    input  logic [TMO_W-1:0]      cfg_timeout,
    output logic [PHASE_W-1:0]    phase_sel,
    output logic                  ets_start,
    input  logic                  ets_done,
    input  logic [ETS_DATA_W-1:0] ets_data,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [PHASE_W-1:0]    res_phase,
    output logic [ETS_DATA_W-1:0] res_data,
    output logic                  busy,
    output logic                  sweep_done,
    output logic                  err_timeout,
    output logic                  err_abort
);

    localparam int DRAIN_W = 2;

    ets_sweep_state_t      r_state, w_state_nxt;
    logic [PHASE_W-1:0]    r_num_steps;
    logic [SETTLE_W-1:0]   r_settle;
    logic [TMO_W-1:0]      r_timeout;
    logic [TMO_W-1:0]      r_wdog;
    logic                  r_abort_mark;
    logic [PHASE_W-1:0]    r_phase_sel;
    logic                  r_ets_start;
    logic                  r_res_valid;
    logic [PHASE_W-1:0]    r_res_phase;
    logic [ETS_DATA_W-1:0] r_res_data;
    logic                  r_busy;
    logic                  r_sweep_done;
    logic                  r_err_timeout;
    logic                  r_err_abort;

    logic                  w_accept, w_capture, w_set_tmo, w_set_abort;
    logic                  w_mark_set, w_phase_inc, w_done_nxt;
    logic                  w_settle_load, w_drain_load;
    logic                  w_settle_zero, w_drain_zero;
    logic [SETTLE_W-1:0]   w_settle_src, w_settle_ld_val;
    logic [TMO_W-1:0]      w_wdog_inc;
    logic                  w_wdog_hit;
    logic                  w_last_phase;

    // The settle timer is loaded with max(settle,1)-1 and RUN follows the
    // cycle in which it reads zero, giving exactly max(settle,1) SETTLE cycles.
    // On sweep start the configuration is not yet latched, so use the port.
    assign w_settle_src    = (r_state == ST_IDLE) ? cfg_settle : r_settle;
    assign w_settle_ld_val = (w_settle_src == '0) ? '0 : (w_settle_src - SETTLE_W'(1));

    // Saturating watchdog; the hit fires in the RUN cycle that brings the
    // count up to the programmed timeout.
    assign w_wdog_inc   = (&r_wdog) ? r_wdog : (r_wdog + TMO_W'(1));
    assign w_wdog_hit   = (r_timeout != '0) && (w_wdog_inc >= r_timeout);
    assign w_last_phase = (r_phase_sel == (r_num_steps - PHASE_W'(1)));

    ets_step_timer #(.CNT_W(SETTLE_W)) u_settle_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (w_settle_load),
        .load_val (w_settle_ld_val),
        .dec      (r_state == ST_SETTLE),
        .zero     (w_settle_zero)
    );

    ets_step_timer #(.CNT_W(DRAIN_W)) u_drain_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (w_drain_load),
        .load_val (DRAIN_W'(ETS_DRAIN_CYC - 1)),
        .dec      (r_state == ST_DRAIN),
        .zero     (w_drain_zero)
    );

    always_comb begin
        w_state_nxt   = r_state;
        w_accept      = 1'b0;
        w_capture     = 1'b0;
        w_set_tmo     = 1'b0;
        w_set_abort   = 1'b0;
        w_mark_set    = 1'b0;
        w_phase_inc   = 1'b0;
        w_done_nxt    = 1'b0;
        w_settle_load = 1'b0;
        w_drain_load  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (sweep_start) begin
                    w_accept = 1'b1;
                    if (cfg_num_steps == '0) begin
                        w_done_nxt = 1'b1;
                    end else begin
                        w_state_nxt   = ST_SETTLE;
                        w_settle_load = 1'b1;
                    end
                end
            end
            ST_SETTLE: begin
                if (sweep_abort) begin
                    w_set_abort  = 1'b1;
                    w_mark_set   = 1'b1;
                    w_state_nxt  = ST_DRAIN;
                    w_drain_load = 1'b1;
                end else if (w_settle_zero) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (sweep_abort) begin
                    w_set_abort  = 1'b1;
                    w_mark_set   = 1'b1;
                    w_state_nxt  = ST_DRAIN;
                    w_drain_load = 1'b1;
                end else if (w_wdog_hit) begin
                    w_set_tmo    = 1'b1;
                    w_mark_set   = 1'b1;
                    w_state_nxt  = ST_DRAIN;
                    w_drain_load = 1'b1;
                end else if (ets_done) begin
                    w_capture    = 1'b1;
                    w_state_nxt  = ST_DRAIN;
                    w_drain_load = 1'b1;
                end
            end
            ST_DRAIN: begin
                // An abort here still lets the drain run out, then drops the result.
                if (sweep_abort) begin
                    w_set_abort = 1'b1;
                    w_mark_set  = 1'b1;
                end
                if (w_drain_zero) begin
                    w_state_nxt = (r_abort_mark || sweep_abort) ? ST_IDLE : ST_OUT;
                end
            end
            ST_OUT: begin
                // res_valid is high throughout OUT, so res_ready alone completes
                // the transfer; a coincident abort takes effect after it.
                if (sweep_abort) begin
                    w_set_abort  = 1'b1;
                    w_mark_set   = 1'b1;
                    w_state_nxt  = ST_DRAIN;
                    w_drain_load = 1'b1;
                end else if (res_ready) begin
                    if (w_last_phase) begin
                        w_state_nxt = ST_IDLE;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_phase_inc   = 1'b1;
                        w_state_nxt   = ST_SETTLE;
                        w_settle_load = 1'b1;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_num_steps   <= '0;
            r_settle      <= '0;
            r_timeout     <= '0;
            r_wdog        <= '0;
            r_abort_mark  <= 1'b0;
            r_phase_sel   <= '0;
            r_ets_start   <= 1'b0;
            r_res_valid   <= 1'b0;
            r_res_phase   <= '0;
            r_res_data    <= '0;
            r_busy        <= 1'b0;
            r_sweep_done  <= 1'b0;
            r_err_timeout <= 1'b0;
            r_err_abort   <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_ets_start  <= (w_state_nxt == ST_RUN);
            r_res_valid  <= (w_state_nxt == ST_OUT);
            r_busy       <= (w_state_nxt != ST_IDLE);
            r_sweep_done <= w_done_nxt;
            r_wdog       <= (r_state == ST_RUN) ? w_wdog_inc : '0;

            if (w_state_nxt == ST_IDLE) begin
                r_abort_mark <= 1'b0;
            end else if (w_mark_set) begin
                r_abort_mark <= 1'b1;
            end

            if (w_accept) begin
                r_num_steps   <= cfg_num_steps;
                r_settle      <= cfg_settle;
                r_timeout     <= cfg_timeout;
                r_phase_sel   <= '0;
                r_err_timeout <= 1'b0;
                r_err_abort   <= 1'b0;
            end
            if (w_set_tmo) begin
                r_err_timeout <= 1'b1;
            end
            if (w_set_abort) begin
                r_err_abort <= 1'b1;
            end
            if (w_capture) begin
                r_res_data  <= ets_data;
                r_res_phase <= r_phase_sel;
            end
            if (w_phase_inc) begin
                r_phase_sel <= r_phase_sel + PHASE_W'(1);
            end
        end
    end

    assign phase_sel   = r_phase_sel;
    assign ets_start   = r_ets_start;
    assign res_valid   = r_res_valid;
    assign res_phase   = r_res_phase;
    assign res_data    = r_res_data;
    assign busy        = r_busy;
    assign sweep_done  = r_sweep_done;
    assign err_timeout = r_err_timeout;
    assign err_abort   = r_err_abort;

endmodule
`default_nettype wire

// File: tb/tb_ets_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_ets_sweep_ctrl
// Description : Directed self-checking bench for ets_sweep_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ets_sweep_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sweep_start = 1'b0;
    logic        sweep_abort = 1'b0;
    logic [7:0]  cfg_num_steps = '0;
    logic [15:0] cfg_settle = '0;
    logic [31:0] cfg_timeout = '0;
    logic [7:0]  phase_sel;
    logic        ets_start;
    logic        ets_done = 1'b0;
    logic [31:0] ets_data = '0;
    logic        res_valid;
    logic        res_ready = 1'b1;
    logic [7:0]  res_phase;
    logic [31:0] res_data;
    logic        busy;
    logic        sweep_done;
    logic        err_timeout;
    logic        err_abort;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    ets_sweep_ctrl #(.PHASE_W(8), .SETTLE_W(16), .TMO_W(32)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .sweep_start   (sweep_start),
        .sweep_abort   (sweep_abort),
        .cfg_num_steps (cfg_num_steps),
        .cfg_settle    (cfg_settle),
        .cfg_timeout   (cfg_timeout),
        .phase_sel     (phase_sel),
        .ets_start     (ets_start),
        .ets_done      (ets_done),
        .ets_data      (ets_data),
        .res_valid     (res_valid),
        .res_ready     (res_ready),
        .res_phase     (res_phase),
        .res_data      (res_data),
        .busy          (busy),
        .sweep_done    (sweep_done),
        .err_timeout   (err_timeout),
        .err_abort     (err_abort)
    );

    // Inputs change and outputs are sampled 1 ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_phase_sel"},   32'(phase_sel),   32'd0);
        check({tag, "_ets_start"},   32'(ets_start),   32'd0);
        check({tag, "_res_valid"},   32'(res_valid),   32'd0);
        check({tag, "_res_phase"},   32'(res_phase),   32'd0);
        check({tag, "_res_data"},    res_data,         32'd0);
        check({tag, "_busy"},        32'(busy),        32'd0);
        check({tag, "_sweep_done"},  32'(sweep_done),  32'd0);
        check({tag, "_err_timeout"}, 32'(err_timeout), 32'd0);
        check({tag, "_err_abort"},   32'(err_abort),   32'd0);
    endtask

    // Ticks until ets_start is seen high, bounded.
    task automatic wait_start(output int n);
        n = 0;
        while ((ets_start !== 1'b1) && (n < 200)) begin
            tick();
            n++;
        end
    endtask

    task automatic start_sweep(input logic [7:0] num, input logic [15:0] settle,
                               input logic [31:0] tmo);
        cfg_num_steps = num;
        cfg_settle    = settle;
        cfg_timeout   = tmo;
        sweep_start   = 1'b1;
        tick();
        sweep_start   = 1'b0;
    endtask

    // One phase with res_ready held high: start latency, accumulate of acc_lat
    // cycles, 2-cycle drain, single-cycle result, then completion status.
    task automatic do_step(input logic [7:0] ph, input logic [31:0] data,
                           input int settle_exp, input int acc_lat, input bit last);
        int n;
        wait_start(n);
        check("settle_latency", 32'(n), 32'(settle_exp));
        check("step_phase_sel", 32'(phase_sel), 32'(ph));
        repeat (acc_lat - 1) tick();
        check("start_held", 32'(ets_start), 32'd1);
        ets_done = 1'b1;
        ets_data = data;
        tick();
        ets_done = 1'b0;
        ets_data = '0;
        check("start_drop", 32'(ets_start), 32'd0);
        check("valid_drain0", 32'(res_valid), 32'd0);
        tick();
        check("valid_drain1", 32'(res_valid), 32'd0);
        tick();
        check("res_valid", 32'(res_valid), 32'd1);
        check("res_phase", 32'(res_phase), 32'(ph));
        check("res_data", res_data, data);
        tick();
        check("valid_after", 32'(res_valid), 32'd0);
        check("step_sweep_done", 32'(sweep_done), 32'(last));
        check("step_busy", 32'(busy), 32'(!last));
    endtask

    initial begin
        int n;

        // ---- Reset state
        tick();
        tick();
        check_all_zero("reset");
        rst_n = 1'b1;
        tick();
        check_all_zero("post_reset");

        // ---- Nominal sweep: 3 steps, settle 4, accumulate 10 cycles
        start_sweep(8'd3, 16'd4, 32'd0);
        check("nom_busy", 32'(busy), 32'd1);
        check("nom_phase0", 32'(phase_sel), 32'd0);
        check("nom_start0", 32'(ets_start), 32'd0);
        do_step(8'd0, 32'd100, 4, 10, 1'b0);
        do_step(8'd1, 32'd200, 4, 10, 1'b0);
        do_step(8'd2, 32'd300, 4, 10, 1'b1);
        check("nom_phase_last", 32'(phase_sel), 32'd2);
        tick();
        check("nom_done_pulse", 32'(sweep_done), 32'd0);
        check("nom_idle_start", 32'(ets_start), 32'd0);

        // ---- Backpressure: 2 steps, res_ready low 7 cycles in OUT
        res_ready = 1'b0;
        start_sweep(8'd2, 16'd1, 32'd0);
        wait_start(n);
        check("bp_latency", 32'(n), 32'd1);
        tick();
        tick();
        ets_done = 1'b1;
        ets_data = 32'hDEAD_BEEF;
        tick();
        ets_done = 1'b0;
        ets_data = '0;
        tick();
        tick();
        check("bp_valid", 32'(res_valid), 32'd1);
        for (int i = 0; i < 6; i++) begin
            tick();
            check("bp_hold_valid", 32'(res_valid), 32'd1);
            check("bp_hold_data", res_data, 32'hDEAD_BEEF);
            check("bp_no_start", 32'(ets_start), 32'd0);
        end
        res_ready = 1'b1;
        tick();
        check("bp_xfer_valid", 32'(res_valid), 32'd0);
        check("bp_phase1", 32'(phase_sel), 32'd1);
        do_step(8'd1, 32'h0000_1234, 1, 4, 1'b1);

        // ---- Watchdog: timeout 20, no ets_done
        start_sweep(8'd1, 16'd2, 32'd20);
        wait_start(n);
        check("wd_latency", 32'(n), 32'd2);
        n = 0;
        while ((ets_start === 1'b1) && (n < 100)) begin
            tick();
            n++;
        end
        check("wd_run_cycles", 32'(n), 32'd20);
        check("wd_err_timeout", 32'(err_timeout), 32'd1);
        check("wd_no_valid", 32'(res_valid), 32'd0);
        check("wd_busy0", 32'(busy), 32'd1);
        tick();
        check("wd_busy1", 32'(busy), 32'd1);
        tick();
        check("wd_idle", 32'(busy), 32'd0);
        check("wd_no_done", 32'(sweep_done), 32'd0);
        check("wd_no_valid2", 32'(res_valid), 32'd0);

        // ---- Abort during RUN at step 1 of 4; start also clears err_timeout
        start_sweep(8'd4, 16'd1, 32'd0);
        check("ab_clr_timeout", 32'(err_timeout), 32'd0);
        do_step(8'd0, 32'd111, 1, 5, 1'b0);
        wait_start(n);
        check("ab_latency", 32'(n), 32'd1);
        check("ab_phase", 32'(phase_sel), 32'd1);
        tick();
        tick();
        sweep_abort = 1'b1;
        tick();
        sweep_abort = 1'b0;
        check("ab_start_drop", 32'(ets_start), 32'd0);
        check("ab_err_abort", 32'(err_abort), 32'd1);
        check("ab_busy", 32'(busy), 32'd1);
        tick();
        tick();
        check("ab_idle", 32'(busy), 32'd0);
        check("ab_no_done", 32'(sweep_done), 32'd0);
        repeat (5) tick();
        check("ab_no_restart", 32'(ets_start), 32'd0);
        check("ab_no_valid", 32'(res_valid), 32'd0);
        check("ab_sticky", 32'(err_abort), 32'd1);

        // ---- num_steps = 0: immediate done, clears err_abort
        start_sweep(8'd0, 16'd3, 32'd0);
        check("z_done", 32'(sweep_done), 32'd1);
        check("z_clr_abort", 32'(err_abort), 32'd0);
        check("z_busy", 32'(busy), 32'd0);
        check("z_start", 32'(ets_start), 32'd0);
        tick();
        check("z_done_pulse", 32'(sweep_done), 32'd0);
        check("z_start2", 32'(ets_start), 32'd0);

        // ---- sweep_start while busy is ignored (would re-latch num_steps=0)
        start_sweep(8'd1, 16'd3, 32'd0);
        tick();
        cfg_num_steps = 8'd0;
        sweep_start   = 1'b1;
        tick();
        sweep_start   = 1'b0;
        check("ign_busy", 32'(busy), 32'd1);
        check("ign_no_done", 32'(sweep_done), 32'd0);
        do_step(8'd0, 32'd77, 1, 2, 1'b1);

        // ---- Reset mid-OUT, then a normal sweep
        res_ready = 1'b0;
        start_sweep(8'd2, 16'd1, 32'd0);
        wait_start(n);
        ets_done = 1'b1;
        ets_data = 32'h5555_AAAA;
        tick();
        ets_done = 1'b0;
        ets_data = '0;
        tick();
        tick();
        check("rst_out_valid", 32'(res_valid), 32'd1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        res_ready = 1'b1;
        check_all_zero("rst_mid");
        start_sweep(8'd1, 16'd2, 32'd0);
        do_step(8'd0, 32'd999, 2, 3, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ets_sweep_ctrl.md
# ets_sweep_ctrl

Sequencer for the equivalent-time-sampling accumulator: it steps a phase index through a programmed number of sample phases. At each phase it runs one accumulate cycle (start/done handshake), captures the 32-bit count and emits it as a (phase, count) result on a valid/ready stream. It sits between the software-facing control registers and the ETS accumulator plus phase-shift logic.

## Interface
Parameters:
- PHASE_W, 8: width of phase index and step count.
- SETTLE_W, 16: width of settle-delay counter.
- TMO_W, 32: width of run watchdog counter.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; synchronous, active-low.
- sweep_start  in  1  single-cycle request; sampled only in IDLE.
- sweep_abort  in  1  level or pulse; honoured in any non-IDLE state.
- cfg_num_steps  in  PHASE_W  phases per sweep; latched on accepted sweep_start.
- cfg_settle  in  SETTLE_W  settle cycles after each phase change; latched.
- cfg_timeout  in  TMO_W  maximum RUN cycles; 0 disables the watchdog; latched.
- phase_sel  out  PHASE_W  phase index to the phase shifter.
- ets_start  out  1  start level to the accumulator.
- ets_done  in  1  accumulator done level.
- ets_data  in  32  accumulator count; valid while ets_done=1.
- res_valid  out  1  result available.
- res_ready  in  1  result consumer accepts.
- res_phase  out  PHASE_W  phase of the result.
- res_data  out  32  captured count.
- busy  out  1  high in every state except IDLE.
- sweep_done  out  1  one-cycle pulse on normal completion.
- err_timeout  out  1  sticky; cleared by the next accepted sweep_start.
- err_abort  out  1  sticky; cleared by the next accepted sweep_start.

## Operation
- States: IDLE, SETTLE, RUN, DRAIN, OUT.
- IDLE + sweep_start:
  - Latch the configuration, clear the error flags and set phase_sel=0.
  - If cfg_num_steps=0: pulse sweep_done on the next cycle and stay in IDLE; ets_start is never raised.
  - Otherwise go to SETTLE.
- SETTLE: count max(cfg_settle,1) cycles, then go to RUN.
- RUN:
  - Hold ets_start=1 and increment the watchdog.
  - On ets_done=1, register ets_data into res_data and phase_sel into res_phase, then go to DRAIN.
  - If the watchdog reaches a nonzero cfg_timeout before ets_done, set err_timeout and go to DRAIN with the abort mark set.
- DRAIN: hold ets_start=0 for exactly 2 cycles, which covers the accumulator's DONE→CLR→IDLE release.
  - Abort mark set: go to IDLE with no result and no sweep_done.
  - Otherwise go to OUT.
- OUT: hold res_valid=1 until res_ready=1, which completes the transfer in that cycle. Then:
  - Last phase (phase_sel = num_steps−1): go to IDLE and pulse sweep_done in the same cycle as the IDLE transition.
  - Otherwise: phase_sel+1, go to SETTLE.
- sweep_abort in SETTLE, RUN or OUT:
  - Set err_abort and the abort mark, drop res_valid, and go to DRAIN.
  - If sweep_abort arrives in DRAIN, the DRAIN count completes and the block returns to IDLE.
- Priority within one cycle:
  - sweep_abort > watchdog > ets_done.
  - In OUT, an abort coincident with res_ready counts as a completed transfer, then aborts.
- ets_done=1 outside RUN is ignored.
- sweep_start while busy is ignored.

## Timing
- Reset values:
  - State IDLE.
  - All outputs 0: phase_sel, ets_start, res_valid, res_phase, res_data, busy, sweep_done, err_timeout, err_abort.
  - Counters 0.
- Reset mid-sweep returns every output to its reset value on the next edge. No result is emitted.
- sweep_start accepted at edge t:
  - busy=1 and phase_sel=0 from t+1.
  - ets_start=1 from t+1+max(cfg_settle,1).
- ets_done seen at edge r:
  - ets_start=0 from r+1.
  - res_valid=1 from r+3.
- Per-step overhead excluding accumulate time and backpressure: settle + 1 (RUN entry) + 2 (DRAIN) + 1 (OUT).
- All outputs are registered. There is no combinational path from ets_done or res_ready to any output.
- The watchdog counter saturates and does not wrap.
- phase_sel never exceeds num_steps−1.

## Structure
- Shared package ets_pkg: state encoding typedef (ets_sweep_state_t), the DRAIN length constant (ETS_DRAIN_CYC=2) and the 32-bit data width constant, also used by the accumulator.
- One natural sub-module, ets_step_timer: a loadable down-counter with a zero flag, instantiated for the settle delay and for the DRAIN delay. The watchdog stays inline.

## Test plan
- Nominal sweep: num_steps=3, settle=4, timeout=0, ets_done returned 10 cycles after each ets_start with data 100/200/300, res_ready tied 1 → three results with (phase, data) = (0,100), (1,200), (2,300), then one sweep_done pulse and busy=0.
- Backpressure: num_steps=2, res_ready low for 7 cycles in OUT → res_valid and res_data held stable, no second ets_start until the transfer completes.
- Watchdog: timeout=20, ets_done never asserted → ets_start drops after 20 RUN cycles, err_timeout=1, no res_valid, IDLE after 2 more cycles.
- Abort during RUN at step 1 of 4 → err_abort=1, ets_start=0 next cycle, no further results, no sweep_done; a following sweep_start clears err_abort.
- num_steps=0 → sweep_done pulses one cycle later, ets_start stays 0; sweep_start while busy is ignored.
- rst_n low for one cycle mid-OUT → all outputs 0 next cycle; a new sweep then runs normally.
